armedf_rom_loader: RTL and testbench
====================================

Name: armedf_rom_loader

Overview:
Sequences the ROM download stream into the shared SDRAM write port. The stream is one byte per strobe from the SPI data path, and arrives only while the download flag is high. The block packs bytes into 16-bit words and maps each byte address into one of four SDRAM banks/regions (CPU, sound, GFX, PROM). Words are buffered in a small FIFO so SDRAM refresh or arbitration stalls do not drop bytes. It also owns the rom_loaded flag and the core-hold output, which drive the armedf core reset.

Parameters:
FIFO_DEPTH, 4, word FIFO entries (power of two, ≥2)
REG1_BASE, 25'h080000, first byte address of region 1 (sound)
REG2_BASE, 25'h0A0000, first byte address of region 2 (GFX)
REG3_BASE, 25'h200000, first byte address of region 3 (PROM/MCU)
PAD_BYTE, 8'hFF, fill for an unpaired final byte

Ports:
clk_sys  in  1  system clock (96 MHz domain)
reset  in  1  asynchronous, active-high
ioctl_downl  in  1  download active, index already qualified to 0
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address of ioctl_dout
ioctl_dout  in  8  download byte
sdram_req  out  1  write request, level
sdram_ack  in  1  one-cycle accept pulse from SDRAM arbiter
sdram_bank  out  2  region index 0..3
sdram_addr  out  23  word address within region
sdram_data  out  16  write word
rom_loaded  out  1  sticky: full image written
core_hold  out  1  hold armedf core in reset
overflow  out  1  sticky: byte lost, FIFO full

Behaviour:
- Reset values: sdram_req=0, sdram_bank=0, sdram_addr=0, sdram_data=0, rom_loaded=0, core_hold=1, overflow=0. FIFO is empty and the state is IDLE.
- Region select (combinational on ioctl_addr):
  - addr<REG1_BASE → 0
  - <REG2_BASE → 1
  - <REG3_BASE → 2
  - else 3
  - Word address = (addr − base)[23:1].
- Packing:
  - Byte with addr[0]=0 is latched into low half; pending flag is set.
  - Byte with addr[0]=1 forms the word {byte, low}, which is pushed the same cycle with the region/word address of that byte.
  - An odd byte with no pending even byte pushes {byte, PAD_BYTE}.
  - A second even byte while pending pushes the previous pending word padded as {PAD_BYTE, low}, then latches the new byte.
- FIFO:
  - Entry = {bank, addr, data}.
  - Push on a full FIFO drops the word and sets overflow (sticky until reset).
  - Simultaneous push and pop on a full FIFO is legal and does not overflow.
- SDRAM handshake:
  - sdram_req=1 whenever the FIFO is non-empty. bank/addr/data present the head entry registered and stay stable while req=1.
  - On sdram_ack the entry is popped; the next head appears the following cycle.
  - Minimum 2 cycles per word. ack while req=0 is ignored.
- State machine:
  - IDLE: core_hold = ~rom_loaded. ioctl_downl rising → LOAD; this clears rom_loaded and the pending flag and sets core_hold=1.
  - LOAD: packing active. ioctl_downl falling → FLUSH; if a byte is pending, {PAD_BYTE, low} is pushed in that cycle.
  - FLUSH: strobes are ignored. When the FIFO is empty and req=0 → DONE.
  - DONE: rom_loaded=1 for one cycle, then → IDLE. core_hold goes to 0 the cycle after entering IDLE.
  - ioctl_downl rising in FLUSH/DONE → LOAD after the FIFO drains. The FIFO is not flushed, and rom_loaded stays 0.
- Reset mid-download: everything returns to reset values immediately. Partial words are discarded. The host must restart the download.
- ioctl_wr with ioctl_downl=0 is ignored.

Decomposition:
- Shared package armedf_pkg holds:
  - region index constants REG_CPU/REG_SND/REG_GFX/REG_PROM
  - loader state enum (IDLE, LOAD, FLUSH, DONE)
  - FIFO entry typedef (41 bits)
- One sub-module: loader_fifo. It is a synchronous FWFT FIFO parameterised on depth and width, with push/pop/full/empty. It uses the same clk_sys and async active-high reset.

Test Plan:
- Download bytes 00..07 at addr 0..7 with ack 1 cycle after req → 4 writes, bank 0, addr 0..3, data 16'h0100,16'h0302,16'h0504,16'h0706. rom_loaded pulses; core_hold falls after the last ack.
- Byte 8'hAB at addr 25'h080001 alone → bank 1, addr 0, data 16'hABFF. Byte 8'h12 at 25'h0A0004 followed by download end → bank 2, addr 2, data 16'hFF12.
- Stall ack for 20 cycles while 10 words are streamed with FIFO_DEPTH=4 → overflow=1 after the 5th push, and exactly 4 words are written. With ack every other cycle → overflow stays 0.
- Full-FIFO push coincident with ack → no overflow, order preserved, head data matches push order.
- Assert reset in LOAD with 2 words queued → sdram_req=0, core_hold=1, rom_loaded=0 the same cycle. A new download then writes correctly from addr 0.
- Re-download after rom_loaded → rom_loaded=0 and core_hold=1 from the ioctl_downl rising edge until the new flush completes.

Source files
------------

// File: rtl/armedf_pkg.sv
// Shared types for the armedf ROM loader: region indices, loader states, FIFO entry.
// No logic; types and constants only.
// Imported by the loader top and referenced by its word FIFO width.
package armedf_pkg;

    // SDRAM region indices presented on sdram_bank
    localparam logic [1:0] REG_CPU  = 2'd0;
    localparam logic [1:0] REG_SND  = 2'd1;
    localparam logic [1:0] REG_GFX  = 2'd2;
    localparam logic [1:0] REG_PROM = 2'd3;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ld_state_t;

    // One queued SDRAM write: region, word address within region, data word
    typedef struct packed {
        logic [1:0]  bank;
        logic [22:0] addr;
        logic [15:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/loader_fifo.sv
// Purpose: small synchronous first-word-fall-through FIFO for queued SDRAM writes.
// Latency: a pushed entry is visible at o_pop_dat the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_pop_dat = r_mem[r_rd_ptr];

    // Storage write; contents need no reset because o_empty gates their use
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/armedf_rom_loader.sv
// Purpose: packs the ROM download byte stream into 16-bit SDRAM writes across four regions and owns rom_loaded/core_hold.
// Latency: a completed word reaches the FIFO the cycle of its odd byte; sdram_req rises one cycle after that.
// Backpressure: up to FIFO_DEPTH words absorb ack stalls; a further word is dropped and flags overflow (sticky).
module armedf_rom_loader
    import armedf_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    // Region bases are assumed word aligned (even)
    parameter logic [24:0] REG1_BASE  = 25'h080000,
    parameter logic [24:0] REG2_BASE  = 25'h0A0000,
    parameter logic [24:0] REG3_BASE  = 25'h200000,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic [1:0]  sdram_bank,
    output logic [22:0] sdram_addr,
    output logic [15:0] sdram_data,
    output logic        rom_loaded,
    output logic        core_hold,
    output logic        overflow
);

    ld_state_t   r_state;
    logic        r_downl_q;
    logic        r_restart;
    logic        r_pend;
    logic [7:0]  r_low;
    logic [1:0]  r_pend_bank;
    logic [22:0] r_pend_addr;
    logic        r_rom_loaded;
    logic        r_core_hold;
    logic        r_overflow;

    logic        r_req;
    logic [1:0]  r_bank;
    logic [22:0] r_addr;
    logic [15:0] r_data;

    logic        w_rise;
    logic [1:0]  w_bank;
    logic [24:0] w_base;
    logic [22:0] w_waddr;
    logic        w_push;
    fifo_entry_t w_push_ent;
    fifo_entry_t w_head;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;

    assign w_rise = ioctl_downl & ~r_downl_q;
    assign w_pop  = r_req & sdram_ack;

    // Region decode of the incoming byte address; with even bases the word
    // offset needs no borrow from bit 0
    always_comb begin
        w_bank = REG_CPU;
        w_base = '0;
        if (ioctl_addr >= REG3_BASE) begin
            w_bank = REG_PROM;
            w_base = REG3_BASE;
        end else if (ioctl_addr >= REG2_BASE) begin
            w_bank = REG_GFX;
            w_base = REG2_BASE;
        end else if (ioctl_addr >= REG1_BASE) begin
            w_bank = REG_SND;
            w_base = REG1_BASE;
        end
        w_waddr = ioctl_addr[23:1] - w_base[23:1];
    end

    // Byte packing: decide whether a word is pushed this cycle and what it holds
    always_comb begin
        w_push     = 1'b0;
        w_push_ent = '0;
        if (r_state == LOAD) begin
            if (!ioctl_downl || (ioctl_wr && !ioctl_addr[0])) begin
                // End of download or a new even byte retires a lone pending low byte
                if (r_pend) begin
                    w_push          = 1'b1;
                    w_push_ent.bank = r_pend_bank;
                    w_push_ent.addr = r_pend_addr;
                    w_push_ent.data = {PAD_BYTE, r_low};
                end
            end else if (ioctl_wr) begin
                w_push          = 1'b1;
                w_push_ent.bank = w_bank;
                w_push_ent.addr = w_waddr;
                w_push_ent.data = {ioctl_dout, (r_pend ? r_low : PAD_BYTE)};
            end
        end
    end

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk      (clk_sys),
        .i_rst      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // SDRAM request stage: hold the head entry until ack, then drop req for a
    // cycle before presenting the next head, giving at least 2 cycles per word
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_bank <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_pop) begin
            r_req <= 1'b0;
        end else if (!r_req && !w_fifo_empty) begin
            r_req  <= 1'b1;
            r_bank <= w_head.bank;
            r_addr <= w_head.addr;
            r_data <= w_head.data;
        end
    end

    // Loader state machine with pending-byte latch and status flags
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_downl_q    <= 1'b0;
            r_restart    <= 1'b0;
            r_pend       <= 1'b0;
            r_low        <= '0;
            r_pend_bank  <= '0;
            r_pend_addr  <= '0;
            r_rom_loaded <= 1'b0;
            r_core_hold  <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            r_downl_q <= ioctl_downl;
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state      <= LOAD;
                        r_rom_loaded <= 1'b0;
                        r_pend       <= 1'b0;
                        r_core_hold  <= 1'b1;
                    end else begin
                        r_core_hold <= ~r_rom_loaded;
                    end
                end
                LOAD: begin
                    if (!ioctl_downl) begin
                        r_state <= FLUSH;
                        r_pend  <= 1'b0;
                    end else if (ioctl_wr) begin
                        if (!ioctl_addr[0]) begin
                            r_pend      <= 1'b1;
                            r_low       <= ioctl_dout;
                            r_pend_bank <= w_bank;
                            r_pend_addr <= w_waddr;
                        end else begin
                            r_pend <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // A new download during the drain resumes loading once empty
                    if (w_rise) begin
                        r_restart <= 1'b1;
                    end
                    if (w_fifo_empty && !r_req) begin
                        if (r_restart || w_rise) begin
                            r_state   <= LOAD;
                            r_restart <= 1'b0;
                            r_pend    <= 1'b0;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (r_restart || w_rise) begin
                        r_state   <= LOAD;
                        r_restart <= 1'b0;
                        r_pend    <= 1'b0;
                    end else begin
                        r_rom_loaded <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sdram_req  = r_req;
    assign sdram_bank = r_bank;
    assign sdram_addr = r_addr;
    assign sdram_data = r_data;
    assign rom_loaded = r_rom_loaded;
    assign core_hold  = r_core_hold;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_armedf_rom_loader.sv
// Bench for armedf_rom_loader: table-driven byte vectors plus hand-written stall,
// coincident push/pop and reset sequences; SDRAM writes checked against a queue.
module tb_armedf_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_downl;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        sdram_req;
    logic        sdram_ack;
    logic [1:0]  sdram_bank;
    logic [22:0] sdram_addr;
    logic [15:0] sdram_data;
    logic        rom_loaded;
    logic        core_hold;
    logic        overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    logic [40:0] exp_q [$];
    bit          stall   = 1'b0;
    bit          man_ack = 1'b0;
    int          ack_gap = 1;

    typedef struct {
        bit          flush;
        logic [24:0] addr;
        logic [7:0]  dat;
        bit          exp;
        logic [1:0]  bank;
        logic [22:0] waddr;
        logic [15:0] wdat;
    } vec_t;

    vec_t vecs [17];

    armedf_rom_loader dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .sdram_bank  (sdram_bank),
        .sdram_addr  (sdram_addr),
        .sdram_data  (sdram_data),
        .rom_loaded  (rom_loaded),
        .core_hold   (core_hold),
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SDRAM arbiter model: acks after ack_gap cycles of req (or on demand) and
    // compares each accepted write with the head of the expected queue
    initial begin : ack_drv
        int hi_cnt;
        hi_cnt    = 0;
        sdram_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            #1;
            if (sdram_ack) begin
                sdram_ack = 1'b0;
                hi_cnt    = 0;
            end else if (sdram_req && (man_ack || (!stall && hi_cnt >= ack_gap))) begin
                sdram_ack = 1'b1;
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got %h expected none",
                             {sdram_bank, sdram_addr, sdram_data});
                end else begin
                    chk("sdram_write", {sdram_bank, sdram_addr, sdram_data}, exp_q.pop_front());
                end
            end else if (sdram_req) begin
                hi_cnt++;
            end
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        ioctl_downl = 1'b0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        exp_q.delete();
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        n_writes = 0;
    endtask

    task automatic start_dl();
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        chk("dl_rom_loaded_clr", rom_loaded, 0);
        chk("dl_core_hold_set", core_hold, 1);
        @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic end_dl(input string tag);
        bit seen;
        bit hold_ok;
        seen        = 1'b0;
        hold_ok     = 1'b1;
        ioctl_downl = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_sys);
            if (rom_loaded) seen = 1'b1;
            else if (!core_hold) hold_ok = 1'b0;
        end
        chk({tag, "_rom_loaded"}, seen, 1);
        chk({tag, "_hold_until_loaded"}, hold_ok && core_hold, 1);
        @(negedge clk_sys);
        chk({tag, "_core_hold_release"}, core_hold, 0);
        chk({tag, "_all_written"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        bit in_dl;

        // Byte vectors: sequential CPU image, then region/pairing corner cases
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{(i == 7), 25'(i), 8'(i), (i % 2 == 1), 2'd0, 23'(i / 2),
                        {8'(i), 8'(i - 1)}};
        end
        vecs[8]  = '{1'b0, 25'h080001, 8'hAB, 1'b1, 2'd1, 23'h0,     16'hABFF};
        vecs[9]  = '{1'b1, 25'h0A0004, 8'h12, 1'b1, 2'd2, 23'h2,     16'hFF12};
        vecs[10] = '{1'b0, 25'h07FFFF, 8'h9A, 1'b1, 2'd0, 23'h3FFFF, 16'h9AFF};
        vecs[11] = '{1'b0, 25'h09FFFE, 8'hAA, 1'b0, 2'd0, 23'h0,     16'h0};
        vecs[12] = '{1'b0, 25'h09FFFF, 8'hBB, 1'b1, 2'd1, 23'hFFFF,  16'hBBAA};
        vecs[13] = '{1'b0, 25'h200000, 8'h34, 1'b0, 2'd0, 23'h0,     16'h0};
        vecs[14] = '{1'b0, 25'h200002, 8'h56, 1'b1, 2'd3, 23'h0,     16'hFF34};
        vecs[15] = '{1'b0, 25'h200003, 8'h78, 1'b1, 2'd3, 23'h1,     16'h7856};
        vecs[16] = '{1'b1, 25'h1FFFFF, 8'hC3, 1'b1, 2'd2, 23'hAFFFF, 16'hC3FF};

        // Reset state
        do_reset();
        chk("rst_req", sdram_req, 0);
        chk("rst_bank", sdram_bank, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_data", sdram_data, 0);
        chk("rst_rom_loaded", rom_loaded, 0);
        chk("rst_core_hold", core_hold, 1);
        chk("rst_overflow", overflow, 0);

        // Table-driven downloads; later downloads are re-downloads after rom_loaded
        ack_gap = 1;
        in_dl   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (!in_dl) begin
                start_dl();
                in_dl = 1'b1;
            end
            if (vecs[i].exp) exp_q.push_back({vecs[i].bank, vecs[i].waddr, vecs[i].wdat});
            send_byte(vecs[i].addr, vecs[i].dat, 1);
            if (vecs[i].flush) begin
                end_dl("vec");
                in_dl = 1'b0;
            end
        end
        chk("vec_overflow", overflow, 0);

        // Stalled arbiter: 10 words into a 4-deep FIFO, only the first 4 survive
        do_reset();
        ack_gap = 1;
        stall   = 1'b1;
        start_dl();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1 && i < 8) exp_q.push_back({2'd0, 23'(i / 2), 8'(i), 8'(i - 1)});
            send_byte(25'(i), 8'(i), 0);
            if (i == 7) chk("ovf_before_5th", overflow, 0);
            if (i == 9) chk("ovf_after_5th", overflow, 1);
        end
        repeat (4) @(negedge clk_sys);
        stall = 1'b0;
        end_dl("ovf");
        chk("ovf_write_count", n_writes, 4);
        chk("ovf_sticky", overflow, 1);

        // Arbiter granting every other cycle keeps up with a continuous stream
        do_reset();
        ack_gap = 0;
        start_dl();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) exp_q.push_back({2'd0, 23'(i / 2), 8'(i), 8'(i - 1)});
            send_byte(25'(i), 8'(i), 0);
        end
        end_dl("alt");
        chk("alt_overflow", overflow, 0);
        chk("alt_write_count", n_writes, 10);

        // Push into a full FIFO in the same cycle as an ack
        do_reset();
        ack_gap = 1;
        stall   = 1'b1;
        start_dl();
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 1) exp_q.push_back({2'd0, 23'(i / 2), 8'(i), 8'(i - 1)});
            send_byte(25'(i), 8'(i), 0);
        end
        chk("full_no_ovf_yet", overflow, 0);
        exp_q.push_back({2'd0, 23'd4, 8'h09, 8'h08});
        ioctl_addr = 25'd9;
        ioctl_dout = 8'h09;
        ioctl_wr   = 1'b1;
        man_ack    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        man_ack  = 1'b0;
        chk("coincident_no_ovf", overflow, 0);
        stall = 1'b0;
        end_dl("coin");
        chk("coin_write_count", n_writes, 5);
        chk("coin_overflow_end", overflow, 0);

        // Reset in LOAD with two words queued, then a clean download
        do_reset();
        ack_gap = 1;
        stall   = 1'b1;
        start_dl();
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i), 0);
        chk("pre_reset_req", sdram_req, 1);
        reset       = 1'b1;
        ioctl_downl = 1'b0;
        #1;
        chk("midrst_req", sdram_req, 0);
        chk("midrst_core_hold", core_hold, 1);
        chk("midrst_rom_loaded", rom_loaded, 0);
        chk("midrst_data", sdram_data, 0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        stall = 1'b0;
        @(negedge clk_sys);
        n_writes = 0;
        start_dl();
        exp_q.push_back({2'd0, 23'd0, 16'h0100});
        exp_q.push_back({2'd0, 23'd1, 16'h0302});
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i), 1);
        end_dl("rst_redl");
        chk("rst_redl_write_count", n_writes, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
